// File: rtl/pixl2sym_ctrl_pkg.sv
// pixl2sym run controller: shared types, default widths and helpers.
// Imported by pixl2sym_run_ctrl and pixl2sym_stall_wdog.
package pixl2sym_ctrl_pkg;

    localparam int DEF_NUM_BLOCK_SIGS = 4;
    localparam int DEF_FRAME_CNT_W    = 16;
    localparam int DEF_WDOG_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_DRAIN,
        ST_ERR
    } run_state_e;

    // Increment v, holding at the all-ones value of a w-bit field.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int          w
    );
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pixl2sym_stall_wdog.sv
// pixl2sym stall watchdog: counts consecutive blocked cycles and flags expiry.
// Ports: enable/clear control, limit (0 = off), block_sigs in; expire pulse, src snapshot out.
module pixl2sym_stall_wdog
    import pixl2sym_ctrl_pkg::*;
#(
    parameter int NUM_BLOCK_SIGS = DEF_NUM_BLOCK_SIGS,
    parameter int WDOG_W         = DEF_WDOG_W
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [WDOG_W-1:0]         limit,
    input  logic [NUM_BLOCK_SIGS-1:0] block_sigs,
    output logic                      expire,
    output logic [NUM_BLOCK_SIGS-1:0] src
);

    logic              any_blk;
    logic [WDOG_W-1:0] cnt;
    logic [WDOG_W-1:0] cnt_inc;

    assign any_blk = |block_sigs;
    assign cnt_inc = WDOG_W'(sat_inc(32'(cnt), WDOG_W));

    // Fires on the blocked cycle that brings the count up to the limit.
    assign expire = enable && (limit != '0) && any_blk
                    && (cnt_inc >= limit);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt <= '0;
            src <= '0;
        end else begin
            if (clear || !enable || !any_blk)
                cnt <= '0;
            else
                cnt <= cnt_inc;

            if (clear)
                src <= '0;
            else if (expire)
                src <= block_sigs;
        end
    end

endmodule

// File: rtl/pixl2sym_run_ctrl.sv
// pixl2sym run controller: launches N ap_ctrl_hs invocations, counts completions, aborts on stall.
// Ports: cfg_* from host, ap_* to kernel, axis_block_sigs in; busy/run_done/frames_done/stall_err/aborted/stall_src status.
// Optional PIXL2SYM_RUN_PERF_EN adds stat_busy_cycles and stat_stall_cycles.
module pixl2sym_run_ctrl
    import pixl2sym_ctrl_pkg::*;
#(
    parameter int NUM_BLOCK_SIGS = DEF_NUM_BLOCK_SIGS,
    parameter int FRAME_CNT_W    = DEF_FRAME_CNT_W,
    parameter int WDOG_W         = DEF_WDOG_W
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      cfg_start,
    input  logic                      cfg_abort,
    input  logic [FRAME_CNT_W-1:0]    cfg_num_frames,
    input  logic [WDOG_W-1:0]         cfg_wdog_limit,
    output logic                      ap_start,
    input  logic                      ap_ready,
    input  logic                      ap_done,
    input  logic                      ap_idle,
    input  logic [NUM_BLOCK_SIGS-1:0] axis_block_sigs,
    output logic                      busy,
    output logic                      run_done,
    output logic [FRAME_CNT_W-1:0]    frames_done,
    output logic                      stall_err,
    output logic                      aborted,
    output logic [NUM_BLOCK_SIGS-1:0] stall_src
`ifdef PIXL2SYM_RUN_PERF_EN
    ,
    output logic [31:0]               stat_busy_cycles,
    output logic [31:0]               stat_stall_cycles
`endif
);

    run_state_e state;
    run_state_e state_nxt;

    logic [FRAME_CNT_W-1:0]    num_q;
    logic [FRAME_CNT_W-1:0]    launched;
    logic [FRAME_CNT_W-1:0]    launched_inc;
    logic [FRAME_CNT_W-1:0]    frames_nxt;
    logic [WDOG_W-1:0]         lim_q;
    logic [NUM_BLOCK_SIGS-1:0] wdog_src;

    logic active;
    logic start_acc;
    logic last_launch;
    logic all_launched;
    logic run_fin;
    logic expire;
    logic err_take;

    assign active    = (state == ST_LAUNCH) || (state == ST_WAIT);
    assign start_acc = cfg_start
                       && ((state == ST_IDLE) || (state == ST_ERR));

    assign launched_inc = launched + FRAME_CNT_W'(1);
    assign frames_nxt   = ap_done
        ? FRAME_CNT_W'(sat_inc(32'(frames_done), FRAME_CNT_W))
        : frames_done;

    assign last_launch  = (state == ST_LAUNCH) && ap_ready
                          && (launched_inc == num_q);
    assign all_launched = (state == ST_WAIT) || last_launch;

    // A completing ap_done outranks a same-cycle watchdog expiry.
    assign run_fin  = active && all_launched && (frames_nxt == num_q);
    assign err_take = active && expire && !cfg_abort && !run_fin;

    pixl2sym_stall_wdog #(
        .NUM_BLOCK_SIGS (NUM_BLOCK_SIGS),
        .WDOG_W         (WDOG_W)
    ) u_wdog (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .enable     (active),
        .clear      (start_acc),
        .limit      (lim_q),
        .block_sigs (axis_block_sigs),
        .expire     (expire),
        .src        (wdog_src)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start_acc && (cfg_num_frames != '0))
                    state_nxt = ST_LAUNCH;
            end
            ST_LAUNCH, ST_WAIT: begin
                if (cfg_abort)
                    state_nxt = ST_DRAIN;
                else if (run_fin)
                    state_nxt = ST_IDLE;
                else if (err_take)
                    state_nxt = ST_ERR;
                else if (last_launch)
                    state_nxt = ST_WAIT;
            end
            ST_DRAIN: begin
                if (ap_idle)
                    state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                if (start_acc)
                    state_nxt = (cfg_num_frames != '0)
                                ? ST_LAUNCH : ST_IDLE;
                else if (cfg_abort)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ap_start = 1'b0;
        busy     = 1'b0;
        unique case (state)
            ST_LAUNCH: begin
                ap_start = 1'b1;
                busy     = 1'b1;
            end
            ST_WAIT, ST_DRAIN: busy = 1'b1;
            default: ;
        endcase
    end

    // The snapshot is only meaningful once the error was actually taken.
    assign stall_src = stall_err ? wdog_src : '0;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            num_q       <= '0;
            lim_q       <= '0;
            launched    <= '0;
            frames_done <= '0;
            stall_err   <= 1'b0;
            aborted     <= 1'b0;
            run_done    <= 1'b0;
        end else begin
            if (start_acc) begin
                num_q       <= cfg_num_frames;
                lim_q       <= cfg_wdog_limit;
                launched    <= '0;
                frames_done <= '0;
                stall_err   <= 1'b0;
                aborted     <= 1'b0;
            end else begin
                if ((state == ST_LAUNCH) && ap_ready)
                    launched <= launched_inc;
                if ((active || (state == ST_DRAIN)) && ap_done)
                    frames_done <= frames_nxt;
                if (err_take)
                    stall_err <= 1'b1;
                if (active && cfg_abort)
                    aborted <= 1'b1;
            end
            run_done <= (start_acc && (cfg_num_frames == '0))
                        || (run_fin && !cfg_abort);
        end
    end

`ifdef PIXL2SYM_RUN_PERF_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stat_busy_cycles  <= '0;
            stat_stall_cycles <= '0;
        end else if (start_acc) begin
            stat_busy_cycles  <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (busy)
                stat_busy_cycles <= sat_inc(stat_busy_cycles, 32);
            if (busy && (|axis_block_sigs))
                stat_stall_cycles <= sat_inc(stat_stall_cycles, 32);
        end
    end
`endif

endmodule
